// File: rtl/mod_barrett_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_barrett_pkg
//  Description : Shared helpers for the parametrised pipelined Barrett
//                modular multiplier: derived widths, latency and the
//                control sideband that rides alongside each operation.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package mod_barrett_pkg;

    // Width of the modulus bit-length field: must hold values 0..WIDTH.
    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Enabled edges from operand capture to result on the output port.
    function automatic int barrett_lat(input int mulStages);
        return 3 * mulStages + 3;
    endfunction

    // Per-stage control sideband. Wider per-operation fields (tag, k, u,
    // modulus) are kept in their own delay lines so that each one is only
    // as deep as the stage that last consumes it.
    typedef struct packed {
        logic valid;
        logic err;
    } sb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pp_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pp_mult_pipe
//  Description : Full-precision unsigned multiplier followed by STAGES
//                register stages (retimable). All stages advance on iEn.
//  Revision    : 1.0  initial release
// ============================================================================
module pp_mult_pipe #(
    parameter int A_W    = 64,
    parameter int B_W    = 64,
    parameter int STAGES = 3
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iEn,
    input  logic [A_W-1:0]       iA,
    input  logic [B_W-1:0]       iB,
    output logic [A_W+B_W-1:0]   oP
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] r_stage [0:STAGES-1];

    // Product is formed into the first stage, later stages only delay it.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else if (iEn) begin
            r_stage[0] <= P_W'(iA) * P_W'(iB);
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign oP = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mod_multiplier_barrett_param_pp.sv
`default_nettype none
// ============================================================================
//  Module      : mod_multiplier_barrett_param_pp
//  Description : Fully pipelined Barrett modular multiplier,
//                oData = (iData0 * iData1) mod iMod. Modulus, bit length
//                and Barrett constant are sampled per operation and travel
//                with it, so consecutive operations may use different moduli.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module mod_multiplier_barrett_param_pp
    import mod_barrett_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 4
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic                        iEn,
    input  logic                        iClr,
    input  logic                        iValid,
    input  logic [TAG_W-1:0]            iTag,
    input  logic [k_width(WIDTH)-1:0]   iK,
    input  logic [WIDTH+1:0]            iU,
    input  logic [WIDTH-1:0]            iData0,
    input  logic [WIDTH-1:0]            iData1,
    input  logic [WIDTH-1:0]            iMod,
    output logic                        oValid,
    output logic [TAG_W-1:0]            oTag,
    output logic [WIDTH-1:0]            oData,
    output logic                        oErr
);

    localparam int K_W  = k_width(WIDTH);
    localparam int LAT  = barrett_lat(MUL_STAGES);
    // Index of the stage where the third multiplier's product is ready.
    localparam int LAST = LAT - 3;

    // Stage 0 operand registers and per-operation delay lines.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    sb_ctrl_t           r_ctrl [0:LAST];
    logic [TAG_W-1:0]   r_tag  [0:LAST];
    logic [WIDTH-1:0]   r_m    [0:LAST];
    logic [K_W-1:0]     r_k    [0:2*MUL_STAGES];
    logic [WIDTH+1:0]   r_u    [0:MUL_STAGES];
    logic [2*WIDTH-1:0] r_pDly [1:2*MUL_STAGES];

    // Tail stages: raw remainder, first correction, output.
    logic [WIDTH+1:0]   r_rVal;
    sb_ctrl_t           r_rCtrl;
    logic [TAG_W-1:0]   r_rTag;
    logic [WIDTH-1:0]   r_rM;
    logic [WIDTH+1:0]   r_s1Val;
    sb_ctrl_t           r_s1Ctrl;
    logic [TAG_W-1:0]   r_s1Tag;
    logic [WIDTH-1:0]   r_s1M;

    sb_ctrl_t           w_inCtrl;
    logic [2*WIDTH-1:0] w_p;
    logic [K_W-1:0]     w_sh1;
    logic [WIDTH:0]     w_q1;
    logic [2*WIDTH+2:0] w_q2;
    logic [K_W-1:0]     w_sh3;
    logic [WIDTH-1:0]   w_q3;
    logic [2*WIDTH-1:0] w_qm;
    logic [WIDTH+1:0]   w_r;
    logic [WIDTH+1:0]   w_rMExt;
    logic [WIDTH+1:0]   w_s1;
    logic [WIDTH+1:0]   w_s1MExt;
    logic [WIDTH+1:0]   w_r2;
    logic               w_resErr;
    logic [WIDTH-1:0]   w_out;

    // Input-side error conditions are decided once at capture and carried along.
    always_comb begin
        w_inCtrl       = '0;
        w_inCtrl.valid = iValid;
        w_inCtrl.err   = (iMod == '0) || (iK == '0) || (iK > K_W'(WIDTH)) ||
                         (iData0 >= iMod) || (iData1 >= iMod);
    end

    // Operand capture; multiplier datapath holds while the pipe is frozen.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_a <= '0;
            r_b <= '0;
            for (int i = 1; i <= 2*MUL_STAGES; i++) begin
                r_pDly[i] <= '0;
            end
        end else if (iEn) begin
            r_a       <= iData0;
            r_b       <= iData1;
            r_pDly[1] <= w_p;
            for (int i = 2; i <= 2*MUL_STAGES; i++) begin
                r_pDly[i] <= r_pDly[i-1];
            end
        end
    end

    // Sideband delay lines aligned with the multiplier stages; flush drops valids.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i <= LAST; i++) begin
                r_ctrl[i] <= '0;
                r_tag[i]  <= '0;
                r_m[i]    <= '0;
            end
            for (int i = 0; i <= 2*MUL_STAGES; i++) begin
                r_k[i] <= '0;
            end
            for (int i = 0; i <= MUL_STAGES; i++) begin
                r_u[i] <= '0;
            end
        end else begin
            if (iEn) begin
                r_ctrl[0] <= w_inCtrl;
                r_tag[0]  <= iTag;
                r_m[0]    <= iMod;
                r_k[0]    <= iK;
                r_u[0]    <= iU;
                for (int i = 1; i <= LAST; i++) begin
                    r_ctrl[i] <= r_ctrl[i-1];
                    r_tag[i]  <= r_tag[i-1];
                    r_m[i]    <= r_m[i-1];
                end
                for (int i = 1; i <= 2*MUL_STAGES; i++) begin
                    r_k[i] <= r_k[i-1];
                end
                for (int i = 1; i <= MUL_STAGES; i++) begin
                    r_u[i] <= r_u[i-1];
                end
            end
            // Later assignment wins: a flush also drops an operation captured this edge.
            if (iClr) begin
                for (int i = 0; i <= LAST; i++) begin
                    r_ctrl[i] <= '0;
                end
            end
        end
    end

    // P = A*B
    pp_mult_pipe #(
        .A_W    (WIDTH),
        .B_W    (WIDTH),
        .STAGES (MUL_STAGES)
    ) u_multAB (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iA     (r_a),
        .iB     (r_b),
        .oP     (w_p)
    );

    // q1 = P >> (K-1); for a valid op P < 2^(2K) so q1 fits in WIDTH+1 bits.
    assign w_sh1 = r_k[MUL_STAGES] - K_W'(1);
    assign w_q1  = (WIDTH+1)'(w_p >> w_sh1);

    // q1 * U
    pp_mult_pipe #(
        .A_W    (WIDTH + 1),
        .B_W    (WIDTH + 2),
        .STAGES (MUL_STAGES)
    ) u_multQU (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iA     (w_q1),
        .iB     (r_u[MUL_STAGES]),
        .oP     (w_q2)
    );

    // q3 = (q1*U) >> (K+1); q3 never exceeds floor(P/M) < M for a valid op.
    assign w_sh3 = r_k[2*MUL_STAGES] + K_W'(1);
    assign w_q3  = WIDTH'(w_q2 >> w_sh3);

    // q3 * M
    pp_mult_pipe #(
        .A_W    (WIDTH),
        .B_W    (WIDTH),
        .STAGES (MUL_STAGES)
    ) u_multQM (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iA     (w_q3),
        .iB     (r_m[2*MUL_STAGES]),
        .oP     (w_qm)
    );

    // Remainder lies in [0, 3M) so WIDTH+2 bits hold it exactly.
    assign w_r      = (WIDTH+2)'(r_pDly[2*MUL_STAGES] - w_qm);
    assign w_rMExt  = {2'b00, r_rM};
    assign w_s1     = (r_rVal >= w_rMExt) ? (r_rVal - w_rMExt) : r_rVal;
    assign w_s1MExt = {2'b00, r_s1M};
    assign w_r2     = (r_s1Val >= w_s1MExt) ? (r_s1Val - w_s1MExt) : r_s1Val;
    assign w_resErr = (w_r2 >= w_s1MExt);
    assign w_out    = (r_s1M == '0) ? '0 : w_r2[WIDTH-1:0];

    // Remainder, two conditional subtracts and output register; bubbles read 0.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_rVal   <= '0;
            r_rCtrl  <= '0;
            r_rTag   <= '0;
            r_rM     <= '0;
            r_s1Val  <= '0;
            r_s1Ctrl <= '0;
            r_s1Tag  <= '0;
            r_s1M    <= '0;
            oValid   <= 1'b0;
            oData    <= '0;
            oTag     <= '0;
            oErr     <= 1'b0;
        end else begin
            if (iEn) begin
                r_rVal   <= w_r;
                r_rCtrl  <= r_ctrl[LAST];
                r_rTag   <= r_tag[LAST];
                r_rM     <= r_m[LAST];
                r_s1Val  <= w_s1;
                r_s1Ctrl <= r_rCtrl;
                r_s1Tag  <= r_rTag;
                r_s1M    <= r_rM;
                oValid   <= r_s1Ctrl.valid;
                if (r_s1Ctrl.valid) begin
                    oData <= w_out;
                    oTag  <= r_s1Tag;
                    oErr  <= r_s1Ctrl.err | w_resErr;
                end else begin
                    oData <= '0;
                    oTag  <= '0;
                    oErr  <= 1'b0;
                end
            end
            if (iClr) begin
                r_rCtrl  <= '0;
                r_s1Ctrl <= '0;
                oValid   <= 1'b0;
                oData    <= '0;
                oTag     <= '0;
                oErr     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_multiplier_barrett_param_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_multiplier_barrett_param_pp
//  Description : Scoreboard bench for the Barrett multiplier. Instance A
//                uses the default 64-bit / 3-stage configuration, instance B
//                a 32-bit / 1-stage configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod_multiplier_barrett_param_pp;

    localparam int LATA = 3 * 3 + 3;
    localparam int LATB = 3 * 1 + 3;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    // Instance A stimulus / response
    logic        enA = 1'b0, clrA = 1'b0, validA = 1'b0;
    logic [3:0]  tagA = '0;
    logic [6:0]  kA = '0;
    logic [65:0] uA = '0;
    logic [63:0] d0A = '0, d1A = '0, mA = '0;
    logic        oValidA, oErrA;
    logic [3:0]  oTagA;
    logic [63:0] oDataA;

    // Instance B stimulus / response
    logic        enB = 1'b0, clrB = 1'b0, validB = 1'b0;
    logic [3:0]  tagB = '0;
    logic [5:0]  kB = '0;
    logic [33:0] uB = '0;
    logic [31:0] d0B = '0, d1B = '0, mB = '0;
    logic        oValidB, oErrB;
    logic [3:0]  oTagB;
    logic [31:0] oDataB;

    mod_multiplier_barrett_param_pp #(.WIDTH(64), .MUL_STAGES(3), .TAG_W(4)) dutA (
        .iClk(clk), .iRstN(rstN), .iEn(enA), .iClr(clrA), .iValid(validA), .iTag(tagA),
        .iK(kA), .iU(uA), .iData0(d0A), .iData1(d1A), .iMod(mA),
        .oValid(oValidA), .oTag(oTagA), .oData(oDataA), .oErr(oErrA)
    );

    mod_multiplier_barrett_param_pp #(.WIDTH(32), .MUL_STAGES(1), .TAG_W(4)) dutB (
        .iClk(clk), .iRstN(rstN), .iEn(enB), .iClr(clrB), .iValid(validB), .iTag(tagB),
        .iK(kB), .iU(uB), .iData0(d0B), .iData1(d1B), .iMod(mB),
        .oValid(oValidB), .oTag(oTagB), .oData(oDataB), .oErr(oErrB)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        err;
        logic        chk;   // compare data only when the result is defined
        int          due;   // enabled-edge count at which the result appears
    } exp_t;

    exp_t scbA[$];
    exp_t scbB[$];
    int   errors = 0;
    int   checks = 0;
    int   cntA = 0, cntB = 0;
    logic edgeEnA = 1'b0, edgeEnB = 1'b0;
    logic [3:0] tagCnt = '0;

    // Count enabled edges so latency can be checked independently of stalls.
    always @(posedge clk) begin
        cntA    <= cntA + (enA ? 1 : 0);
        cntB    <= cntB + (enB ? 1 : 0);
        edgeEnA <= enA & rstN;
        edgeEnB <= enB & rstN;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor A: pop and compare whenever a fresh result is presented.
    always @(negedge clk) begin : monA
        exp_t e;
        if (edgeEnA && oValidA) begin
            checks++;
            if (scbA.size() == 0) begin
                errors++;
                $display("FAIL resA unexpected: tag=%0d data=%0h err=%0b", oTagA, oDataA, oErrA);
            end else begin
                e = scbA.pop_front();
                if (oTagA !== e.tag || oErrA !== e.err || (e.chk && oDataA !== e.data) || cntA != e.due) begin
                    errors++;
                    $display("FAIL resA: got tag=%0d data=%0h err=%0b edge=%0d want tag=%0d data=%0h err=%0b edge=%0d",
                             oTagA, oDataA, oErrA, cntA, e.tag, e.data, e.err, e.due);
                end
            end
        end else if (edgeEnA) begin
            chk("bubbleA", {oDataA, oTagA, oErrA}, '0);
        end
    end

    // Monitor B
    always @(negedge clk) begin : monB
        exp_t e;
        if (edgeEnB && oValidB) begin
            checks++;
            if (scbB.size() == 0) begin
                errors++;
                $display("FAIL resB unexpected: tag=%0d data=%0h err=%0b", oTagB, oDataB, oErrB);
            end else begin
                e = scbB.pop_front();
                if (oTagB !== e.tag || oErrB !== e.err || (e.chk && oDataB !== e.data[31:0]) || cntB != e.due) begin
                    errors++;
                    $display("FAIL resB: got tag=%0d data=%0h err=%0b edge=%0d want tag=%0d data=%0h err=%0b edge=%0d",
                             oTagB, oDataB, oErrB, cntB, e.tag, e.data, e.err, e.due);
                end
            end
        end
    end

    function automatic logic [65:0] calcU(input logic [63:0] m, input int k);
        logic [129:0] num;
        num = 130'd1 << (2 * k);
        return 66'(num / {66'd0, m});
    endfunction

    // Drive one slot on A (called just after a falling edge).
    task automatic opA(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                       input logic [6:0] k, input logic [65:0] u, input logic [3:0] tag,
                       input logic [63:0] ed, input logic ee, input logic dataChk);
        enA = 1'b1; clrA = 1'b0; validA = v; d0A = a; d1A = b; mA = m; kA = k; uA = u; tagA = tag;
        if (v) scbA.push_back('{data: ed, tag: tag, err: ee, chk: dataChk, due: cntA + 1 + LATA});
        @(negedge clk);
    endtask

    task automatic opB(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                       input logic [5:0] k, input logic [33:0] u, input logic [3:0] tag,
                       input logic [31:0] ed, input logic ee, input logic dataChk);
        enB = 1'b1; clrB = 1'b0; validB = v; d0B = a; d1B = b; mB = m; kB = k; uB = u; tagB = tag;
        if (v) scbB.push_back('{data: {32'd0, ed}, tag: tag, err: ee, chk: dataChk, due: cntB + 1 + LATB});
        @(negedge clk);
    endtask

    task automatic randOpA();
        logic [63:0]  m, a, b;
        logic [127:0] p;
        m = {1'b1, 31'($urandom), 32'($urandom)};
        a = {$urandom, $urandom} % m;
        b = {$urandom, $urandom} % m;
        p = {64'd0, a} * {64'd0, b};
        opA(1'b1, a, b, m, 7'd64, calcU(m, 64), tagCnt, 64'(p % {64'd0, m}), 1'b0, 1'b1);
        tagCnt = tagCnt + 4'd1;
    endtask

    task automatic randOpB();
        logic [31:0] m, a, b;
        logic [63:0] p;
        m = {1'b1, 31'($urandom)};
        a = 32'($urandom) % m;
        b = 32'($urandom) % m;
        p = {32'd0, a} * {32'd0, b};
        opB(1'b1, a, b, m, 6'd32, 34'(calcU({32'd0, m}, 32)), tagCnt, 32'(p % {32'd0, m}), 1'b0, 1'b1);
        tagCnt = tagCnt + 4'd1;
    endtask

    task automatic idleA(input int n, input logic expectQuiet);
        for (int i = 0; i < n; i++) begin
            opA(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
            if (expectQuiet) chk("quietA", {127'd0, oValidA}, '0);
        end
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        logic [69:0] snap;
        repeat (2) @(negedge clk);
        chk("resetA", {57'd0, oValidA, oErrA, oTagA, oDataA}, '0);
        chk("resetB", {89'd0, oValidB, oErrB, oTagB, oDataB}, '0);
        rstN = 1'b1;
        @(negedge clk);

        // Directed vectors on A, back to back with one bubble.
        opA(1, 64'd1467, 64'd2489, 64'd7681, 7'd13, 66'd8736, 4'd3, 64'd2888, 0, 1);
        opA(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64,
            66'h1_0000_0000_0000_0001, 4'd4, 64'd1, 0, 1);
        opA(1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 66'h1_0000_0000_0000_0001, 4'd5, 64'd0, 0, 1);
        opA(0, 64'd9, 64'd9, 64'd7681, 7'd13, 66'd8736, 4'd0, 64'd0, 0, 0);
        opA(1, 64'd7680, 64'd7680, 64'd7681, 7'd13, 66'd8736, 4'd6, 64'd1, 0, 1);
        opA(1, 64'd1234, 64'd0, 64'd7681, 7'd13, 66'd8736, 4'd7, 64'd0, 0, 1);
        opA(1, 64'd5, 64'd7, 64'd0, 7'd13, 66'd0, 4'd8, 64'd0, 1, 1);          // M = 0
        opA(1, 64'd7681, 64'd2, 64'd7681, 7'd13, 66'd8736, 4'd9, 64'd0, 1, 0); // A = M
        opA(1, 64'd100, 64'd200, 64'd7681, 7'd0, 66'd8736, 4'd10, 64'd0, 1, 0); // K = 0
        opA(1, 64'd100, 64'd200, 64'd7681, 7'd65, 66'd8736, 4'd11, 64'd0, 1, 0); // K > WIDTH
        opA(1, 64'd7680, 64'd7680, 64'd7681, 7'd13, 66'd0, 4'd12, 64'd0, 1, 0);  // U wrong: residue stays >= M
        idleA(LATA + 2, 1'b0);
        chk("drainDirA", 128'(scbA.size()), '0);

        // Streaming with a 5-cycle stall in the middle.
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                enA = 1'b0; validA = 1'b1;
                snap = {oValidA, oErrA, oTagA, oDataA};
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stallHold", {58'd0, oValidA, oErrA, oTagA, oDataA}, {58'd0, snap});
                end
            end
            randOpA();
        end
        idleA(LATA + 2, 1'b0);
        chk("drainStreamA", 128'(scbA.size()), '0);

        // Flush with operations in flight; the op presented with iClr is dropped.
        for (int i = 0; i < 18; i++) randOpA();
        enA = 1'b1; clrA = 1'b1; validA = 1'b1;
        @(negedge clk);
        clrA = 1'b0;
        scbA.delete();
        chk("clrOut", {57'd0, oValidA, oErrA, oTagA, oDataA}, '0);
        idleA(LATA + 2, 1'b1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 16; i++) randOpA();
        validA = 1'b0;
        #2 rstN = 1'b0;
        #1 chk("rstMidOut", {57'd0, oValidA, oErrA, oTagA, oDataA}, '0);
        scbA.delete();
        @(negedge clk);
        rstN = 1'b1;
        idleA(LATA + 2, 1'b1);

        // Narrow, single-stage configuration.
        opB(1, 32'd1467, 32'd2489, 32'd7681, 6'd13, 34'd8736, 4'd3, 32'd2888, 0, 1);
        opB(1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd32, 34'h1_0000_0001, 4'd4, 32'd1, 0, 1);
        opB(1, 32'd5, 32'd7, 32'd0, 6'd13, 34'd0, 4'd5, 32'd0, 1, 1);
        opB(1, 32'd7681, 32'd2, 32'd7681, 6'd13, 34'd8736, 4'd6, 32'd0, 1, 0);
        for (int i = 0; i < 20; i++) randOpB();
        for (int i = 0; i < LATB + 2; i++) opB(0, '0, '0, '0, '0, '0, '0, '0, 0, 0);
        chk("drainB", 128'(scbB.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
